wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter DEPTH, default 2, multicycle result queue entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pipe_we  input  1  main-pipeline writeback request this cycle.
REQ-007 SHALL have port pipe_waddr  input  ADDR_W  main-pipeline destination register.
REQ-008 SHALL have port pipe_wdata  input  DATA_W  main-pipeline write data.
REQ-009 SHALL have port mc_valid  input  1  multicycle unit result offered.
REQ-010 SHALL have port mc_waddr  input  ADDR_W  multicycle destination register.
REQ-011 SHALL have port mc_wdata  input  DATA_W  multicycle result.
REQ-012 SHALL have port mc_ready  output  1  queue accepts result this cycle.
REQ-013 SHALL have port raddr1  input  ADDR_W  decode-stage read address, port 1.
REQ-014 SHALL have port raddr2  input  ADDR_W  decode-stage read address, port 2.
REQ-015 SHALL have port pend_hit1  output  1  raddr1 matches a queued entry.
REQ-016 SHALL have port pend_hit2  output  1  raddr2 matches a queued entry.
REQ-017 SHALL have port we  output  1  register file write enable.
REQ-018 SHALL have port waddr  output  ADDR_W  register file write address.
REQ-019 SHALL have port wdata  output  DATA_W  register file write data.
REQ-020 SHALL have port q_cnt  output  log2(DEPTH)+1  registered queue occupancy.

Function
REQ-021 SHALL treat a pipe write as effective only when pipe_we=1 and pipe_waddr!=0.
REQ-022 SHALL drive we/waddr/wdata combinationally from the effective pipe write, zero latency, highest priority.
REQ-023 SHALL, with no effective pipe write and queue non-empty, drive we=1 and head entry's addr/data, and pop the head at the clock edge.
REQ-024 SHALL, with neither source, drive we=0, waddr=0, wdata=0.
REQ-025 SHALL never stall the pipe path; queue drains only in cycles without an effective pipe write.
REQ-026 SHALL drive mc_ready=1 iff q_cnt<DEPTH and rst=0; a pop in the same cycle SHALL NOT raise mc_ready when full.
REQ-027 SHALL accept a result when mc_valid=1 and mc_ready=1; accepted entry becomes visible at head no earlier than the next cycle (no same-cycle bypass).
REQ-028 SHALL accept but discard (not enqueue) results with mc_waddr=0.
REQ-029 SHALL allow simultaneous push and pop: q_cnt unchanged, FIFO order preserved, pointers wrap modulo DEPTH.
REQ-030 SHALL, on an effective pipe write, invalidate every queued valid entry whose addr equals pipe_waddr (pipe value is newer); invalidated entries are skipped when at head and not written.
REQ-031 SHALL NOT invalidate an entry being pushed in the same cycle as a matching pipe write.
REQ-032 SHALL count invalidated entries in q_cnt until removed; a skipped head is removed in one cycle with we driven by the next rule (no bubble required, one allowed).
REQ-033 SHALL drive pend_hitN=1 iff raddrN!=0 and equals the addr of any valid queued entry or of the result being accepted this cycle.
REQ-034 SHALL keep q_cnt within 0..DEPTH; overflow and underflow are impossible by construction.

Reset
REQ-035 SHALL, while rst=1, asynchronously clear all entries, pointers, and q_cnt to 0, and hold mc_ready=0, we=0, waddr=0, wdata=0, pend_hit1/2=0.
REQ-036 SHALL discard a result offered in the cycle rst deasserts only if mc_ready was 0 at that edge.

Verification
REQ-037 SHALL verify: pipe_we=1, pipe_waddr=3, pipe_wdata=0x11 -> same cycle we=1, waddr=3, wdata=0x11; q_cnt stays 0.
REQ-038 SHALL verify: mc push addr 5 data 0xAA, no pipe traffic -> next cycle we=1, waddr=5, wdata=0xAA, q_cnt 1->0; pend_hit1=1 for raddr1=5 until popped.
REQ-039 SHALL verify: pushes to 6 and 7 while pipe writes every cycle -> q_cnt=2, mc_ready=0; pipe idle -> writes 6 then 7 in order, mc_ready returns 1.
REQ-040 SHALL verify: queue holds addr 9 data 0x1, pipe writes addr 9 data 0x2 -> entry skipped, regfile never receives 0x1 after 0x2.
REQ-041 SHALL verify: mc push addr 0 -> mc_ready=1, q_cnt stays 0, we stays 0.
REQ-042 SHALL verify: rst asserted mid-operation with q_cnt=2 -> immediately q_cnt=0, we=0, mc_ready=0; after release, no stale writes.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the main pipeline always wins the single write
// port; multicycle results wait in a small FIFO and drain in idle pipe cycles.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [ADDR_W-1:0]        pipe_waddr,
    input  logic [DATA_W-1:0]        pipe_wdata,
    input  logic                     mc_valid,
    input  logic [ADDR_W-1:0]        mc_waddr,
    input  logic [DATA_W-1:0]        mc_wdata,
    output logic                     mc_ready,
    input  logic [ADDR_W-1:0]        raddr1,
    input  logic [ADDR_W-1:0]        raddr2,
    output logic                     pend_hit1,
    output logic                     pend_hit2,
    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    output logic [$clog2(DEPTH):0]   q_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic              ent_valid [DEPTH];
    logic [ADDR_W-1:0] ent_addr  [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    logic pipe_eff;
    logic push;
    logic enq;
    logic pop;
    logic empty;
    logic hit1;
    logic hit2;

    assign pipe_eff = pipe_we && (pipe_waddr != '0);
    assign empty    = (q_cnt == '0);
    assign mc_ready = !rst && (q_cnt < CNT_FULL);
    assign push     = mc_valid && mc_ready;
    // Results targeting r0 are handshaked but never stored.
    assign enq      = push && (mc_waddr != '0);

    // Pop happens whether or not the head is still valid; a stale head costs one idle slot.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        pop   = 1'b0;
        if (!rst) begin
            if (pipe_eff) begin
                we    = 1'b1;
                waddr = pipe_waddr;
                wdata = pipe_wdata;
            end else if (!empty) begin
                pop = 1'b1;
                if (ent_valid[rd_ptr]) begin
                    we    = 1'b1;
                    waddr = ent_addr[rd_ptr];
                    wdata = ent_data[rd_ptr];
                end
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == raddr1)) hit1 = 1'b1;
            if (ent_valid[i] && (ent_addr[i] == raddr2)) hit2 = 1'b1;
        end
        if (push && (mc_waddr == raddr1)) hit1 = 1'b1;
        if (push && (mc_waddr == raddr2)) hit2 = 1'b1;
        pend_hit1 = !rst && (raddr1 != '0) && hit1;
        pend_hit2 = !rst && (raddr2 != '0) && hit2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
                ent_addr[i]  <= '0;
                ent_data[i]  <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (pipe_eff) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_addr[i] == pipe_waddr) ent_valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_ONE;
            end
            // Written last so a same-cycle matching pipe write cannot kill the new entry.
            if (enq) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_addr[wr_ptr]  <= mc_waddr;
                ent_data[wr_ptr]  <= mc_wdata;
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            case ({enq, pop})
                2'b10:   q_cnt <= q_cnt + CNT_ONE;
                2'b01:   q_cnt <= q_cnt - CNT_ONE;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: expected register-file writes are queued as stimulus is
// driven and matched in order against every cycle the DUT asserts we.
module tb_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_waddr;
    logic [DATA_W-1:0] mc_wdata;
    logic              mc_ready;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              pend_hit1;
    logic              pend_hit2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        q_cnt;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q [$];
    int  vectors     = 0;
    int  miscompares = 0;

    wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
        .raddr1(raddr1), .raddr2(raddr2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .we(we), .waddr(waddr), .wdata(wdata), .q_cnt(q_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every write the DUT performs must be the next expected one.
    always @(negedge clk) begin
        if (!rst && we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", waddr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (waddr !== e.a || wdata !== e.d) begin
                    miscompares++;
                    $display("FAIL write_order: got addr %0d data 0x%0h, required addr %0d data 0x%0h",
                             waddr, wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic drive_idle();
        pipe_we  = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        mc_valid = 1'b0; mc_waddr   = '0; mc_wdata   = '0;
    endtask

    task automatic pipe_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pipe_we = 1'b1; pipe_waddr = a; pipe_wdata = d;
        if (a != '0) exp_q.push_back('{a: a, d: d});
    endtask

    task automatic mc_offer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mc_valid = 1'b1; mc_waddr = a; mc_wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive_idle(); raddr1 = 5'd3; raddr2 = '0;
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h55;
        #2;
        vectors++;
        if (q_cnt !== 2'd0 || mc_ready !== 1'b0 || we !== 1'b0 || waddr !== '0 || wdata !== '0
            || pend_hit1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got q_cnt=%0d mc_ready=%b we=%b waddr=%0d wdata=0x%0h hit1=%b, required all zero",
                     q_cnt, mc_ready, we, waddr, wdata, pend_hit1);
        end
        drive_idle();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (mc_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b, required 1", mc_ready);
        end
    endtask

    task automatic test_pipe_write();
        next_cycle();
        pipe_wr(5'd3, 32'h11);
        @(negedge clk);
        vectors++;
        if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h11) begin
            miscompares++;
            $display("FAIL pipe_zero_latency: got we=%b addr %0d data 0x%0h, required 1/3/0x11", we, waddr, wdata);
        end
        next_cycle();
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
        @(negedge clk);
        vectors++;
        if (we !== 1'b0 || q_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL pipe_r0_ignored: got we=%b q_cnt=%0d, required we=0 q_cnt=0", we, q_cnt);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_mc_push();
        next_cycle();
        raddr1 = 5'd5;
        mc_offer(5'd5, 32'hAA);
        exp_q.push_back('{a: 5'd5, d: 32'hAA});
        @(negedge clk);
        vectors++;
        if (mc_ready !== 1'b1 || pend_hit1 !== 1'b1 || q_cnt !== 2'd0 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL mc_accept_cycle: got ready=%b hit1=%b q_cnt=%0d we=%b, required 1/1/0/0",
                     mc_ready, pend_hit1, q_cnt, we);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        vectors++;
        if (q_cnt !== 2'd1 || pend_hit1 !== 1'b1) begin
            miscompares++;
            $display("FAIL mc_queued: got q_cnt=%0d hit1=%b, required 1/1", q_cnt, pend_hit1);
        end
        next_cycle();
        vectors++;
        if (q_cnt !== 2'd0 || pend_hit1 !== 1'b0) begin
            miscompares++;
            $display("FAIL mc_drained: got q_cnt=%0d hit1=%b, required 0/0", q_cnt, pend_hit1);
        end
        raddr1 = '0;
    endtask

    task automatic test_full_queue();
        next_cycle();
        pipe_wr(5'd1, 32'h100); mc_offer(5'd6, 32'h66);
        next_cycle();
        pipe_wr(5'd2, 32'h200); mc_offer(5'd7, 32'h77);
        next_cycle();
        pipe_wr(5'd3, 32'h300); mc_offer(5'd8, 32'h88);
        raddr1 = 5'd8; raddr2 = 5'd7;
        @(negedge clk);
        vectors++;
        if (q_cnt !== 2'd2 || mc_ready !== 1'b0 || pend_hit1 !== 1'b0 || pend_hit2 !== 1'b1) begin
            miscompares++;
            $display("FAIL full_state: got q_cnt=%0d ready=%b hit1=%b hit2=%b, required 2/0/0/1",
                     q_cnt, mc_ready, pend_hit1, pend_hit2);
        end
        next_cycle();
        drive_idle();
        exp_q.push_back('{a: 5'd6, d: 32'h66});
        exp_q.push_back('{a: 5'd7, d: 32'h77});
        @(negedge clk);
        vectors++;
        if (mc_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_while_popping_full: got %b, required 0", mc_ready);
        end
        next_cycle();
        vectors++;
        if (mc_ready !== 1'b1 || q_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL ready_restored: got ready=%b q_cnt=%0d, required 1/1", mc_ready, q_cnt);
        end
        next_cycle();
        raddr1 = '0; raddr2 = '0;
    endtask

    task automatic test_invalidate();
        next_cycle();
        mc_offer(5'd9, 32'h1);
        next_cycle();
        drive_idle();
        pipe_wr(5'd9, 32'h2);
        next_cycle();
        drive_idle();
        raddr1 = 5'd9;
        @(negedge clk);
        vectors++;
        if (q_cnt !== 2'd1 || pend_hit1 !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_entry: got q_cnt=%0d hit1=%b, required 1/0", q_cnt, pend_hit1);
        end
        next_cycle();
        vectors++;
        if (q_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL stale_removed: got q_cnt=%0d, required 0", q_cnt);
        end
        // Same-cycle push and matching pipe write: the queued result is newer and must survive.
        pipe_wr(5'd10, 32'hA0); mc_offer(5'd10, 32'hB0);
        exp_q.push_back('{a: 5'd10, d: 32'hB0});
        next_cycle();
        drive_idle();
        next_cycle();
        vectors++;
        if (q_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL push_vs_pipe_drain: got q_cnt=%0d, required 0", q_cnt);
        end
        raddr1 = '0;
    endtask

    task automatic test_zero_addr();
        next_cycle();
        mc_offer(5'd0, 32'hFF);
        @(negedge clk);
        vectors++;
        if (mc_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL r0_ready: got %b, required 1", mc_ready);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        vectors++;
        if (q_cnt !== 2'd0 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_discard: got q_cnt=%0d we=%b, required 0/0", q_cnt, we);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            mc_offer(ADDR_W'(11 + i), DATA_W'(32'hC00 + i));
            exp_q.push_back('{a: ADDR_W'(11 + i), d: DATA_W'(32'hC00 + i)});
            if (i > 0) begin
                vectors++;
                if (q_cnt !== 2'd1) begin
                    miscompares++;
                    $display("FAIL stream_q_cnt[%0d]: got %0d, required 1", i, q_cnt);
                end
            end
        end
        next_cycle();
        drive_idle();
        next_cycle();
        vectors++;
        if (q_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL stream_drained: got q_cnt=%0d, required 0", q_cnt);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        pipe_wr(5'd1, 32'h31); mc_offer(5'd20, 32'hC1);
        next_cycle();
        pipe_wr(5'd2, 32'h32); mc_offer(5'd21, 32'hC2);
        next_cycle();
        drive_idle();
        raddr1 = 5'd20;
        vectors++;
        if (q_cnt !== 2'd2) begin
            miscompares++;
            $display("FAIL prefill: got q_cnt=%0d, required 2", q_cnt);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (q_cnt !== 2'd0 || we !== 1'b0 || mc_ready !== 1'b0 || pend_hit1 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got q_cnt=%0d we=%b ready=%b hit1=%b, required 0/0/0/0",
                     q_cnt, we, mc_ready, pend_hit1);
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) next_cycle();
        vectors++;
        if (q_cnt !== 2'd0 || pend_hit1 !== 1'b0 || mc_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: got q_cnt=%0d hit1=%b ready=%b, required 0/0/1",
                     q_cnt, pend_hit1, mc_ready);
        end
        raddr1 = '0;
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_mc_push();
        test_full_queue();
        test_invalidate();
        test_zero_addr();
        test_back_to_back();
        test_reset_mid();
        next_cycle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: got %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
